// File: rtl/breath_pkg.sv
// Shared types for the breathing-light duty generator and the blocks that consume its phase output.
package breath_pkg;

    typedef enum logic [1:0] {
        PH_RISE    = 2'd0,
        PH_HOLD_HI = 2'd1,
        PH_FALL    = 2'd2,
        PH_HOLD_LO = 2'd3
    } phase_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every STEP_DIV enabled clocks; the count freezes while enable is low.
module tick_gen #(
    parameter int unsigned STEP_DIV = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign tick = enable && (count_q == CNT_LAST);

    always_comb begin
        count_d = count_q;
        if (enable) begin
            count_d = tick ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/breath_duty_gen.sv
// Triangle-wave duty generator (rise, hold high, fall, hold low) feeding the PWM stage over valid/ready.
// Define BREATH_GAMMA_EN to square the level into the duty value (perceptual gamma ~2).
module breath_duty_gen
    import breath_pkg::*;
#(
    parameter int unsigned STEP_DIV   = 50_000,
    parameter int unsigned DUTY_W     = 8,
    parameter int unsigned MIN_LVL    = 0,
    parameter int unsigned MAX_LVL    = 255,
    parameter int unsigned HOLD_STEPS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              duty_ready,
    output logic              duty_valid,
    output logic [DUTY_W-1:0] duty,
    output logic [1:0]        phase,
    output logic              cycle_done
);

    localparam int unsigned HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [DUTY_W-1:0] MIN_L = DUTY_W'(MIN_LVL);
    localparam logic [DUTY_W-1:0] MAX_L = DUTY_W'(MAX_LVL);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);
    localparam bit NO_HOLD = (HOLD_STEPS == 0);

    logic              tick;
    logic              issue;
    phase_t            phase_q, phase_d;
    logic [DUTY_W-1:0] level_q, level_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [DUTY_W-1:0] duty_q, duty_d, duty_new;
    logic              valid_q, valid_d;
    logic              cycle_done_q, cycle_done_d;

    tick_gen #(
        .STEP_DIV(STEP_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(enable),
        .tick  (tick)
    );

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        phase_d      = phase_q;
        level_d      = level_q;
        hold_cnt_d   = hold_cnt_q;
        cycle_done_d = 1'b0;
        if (tick) begin
            unique case (phase_q)
                PH_RISE: begin
                    if (level_q != MAX_L) level_d = level_q + DUTY_W'(1);
                    if (level_d == MAX_L) begin
                        hold_cnt_d = '0;
                        phase_d    = NO_HOLD ? PH_FALL : PH_HOLD_HI;
                    end
                end
                PH_HOLD_HI: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = '0;
                        phase_d    = PH_FALL;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                PH_FALL: begin
                    if (level_q != MIN_L) level_d = level_q - DUTY_W'(1);
                    if (level_d == MIN_L) begin
                        hold_cnt_d = '0;
                        if (NO_HOLD) begin
                            phase_d      = PH_RISE;
                            cycle_done_d = 1'b1;
                        end else begin
                            phase_d = PH_HOLD_LO;
                        end
                    end
                end
                PH_HOLD_LO: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d   = '0;
                        phase_d      = PH_RISE;
                        cycle_done_d = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                default: phase_d = PH_RISE;
            endcase
        end
    end

    // Only level-changing ticks produce a duty value; hold ticks leave the output untouched.
    assign issue = tick && (level_d != level_q);

`ifdef BREATH_GAMMA_EN
    logic [2*DUTY_W-1:0] level_sq;
    assign level_sq = {{DUTY_W{1'b0}}, level_d} * {{DUTY_W{1'b0}}, level_d};
    assign duty_new = DUTY_W'(level_sq >> DUTY_W);
`else
    assign duty_new = level_d;
`endif

    // Latest value wins: a pending, unaccepted duty is simply overwritten so the generator never stalls.
    always_comb begin
        duty_d  = duty_q;
        valid_d = valid_q;
        if (issue) begin
            duty_d  = duty_new;
            valid_d = 1'b1;
        end else if (valid_q && duty_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= PH_RISE;
            level_q      <= MIN_L;
            hold_cnt_q   <= '0;
            duty_q       <= '0;
            valid_q      <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            level_q      <= level_d;
            hold_cnt_q   <= hold_cnt_d;
            duty_q       <= duty_d;
            valid_q      <= valid_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign duty_valid = valid_q;
    assign duty       = duty_q;
    assign phase      = phase_q;
    assign cycle_done = cycle_done_q;

endmodule
